// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared port ids, error word and sizing helper for rom_arbiter
package rom_arb_pkg;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  // Word returned in place of rom contents for a bad address
  localparam int unsigned ERR_DATA = 0;

  // Width of the back-to-back data grant counter; never narrower than one bit
  function automatic int unsigned consec_w(input int unsigned max_consec);
    return (max_consec < 2) ? 1 : $clog2(max_consec + 1);
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - fetch/data request ports, shared response and rom bus of rom_arbiter
interface rom_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rsp_valid;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, d_req, d_addr, rom_data,
    output f_gnt, f_rsp_valid, d_gnt, d_rsp_valid, rsp_data, rsp_err, rom_address
  );

  // Requester and rom side
  modport master (
    output f_req, f_addr, d_req, d_addr, rom_data,
    input  f_gnt, f_rsp_valid, d_gnt, d_rsp_valid, rsp_data, rsp_err, rom_address
  );

endinterface

// File: rtl/rom_arb_pick.sv
// rtl/rom_arb_pick.sv - combinational grant decision; ROM_ARB_RR_EN selects round-robin
module rom_arb_pick
  import rom_arb_pkg::*;
#(
  parameter int MAX_CONSEC = 3,
  parameter int CW         = 2
) (
  input  logic          f_req_i,
  input  logic          d_req_i,
  input  port_e         last_gnt_i,
`ifndef ROM_ARB_RR_EN
  input  logic [CW-1:0] consec_i,
`endif
  output logic          f_gnt_o,
  output logic          d_gnt_o
);

`ifndef ROM_ARB_RR_EN
  // Priority mode breaks ties by the starvation counter, not by history
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;
`endif

  // One grant at most; contention resolved by the configured policy
  always_comb begin
    f_gnt_o = 1'b0;
    d_gnt_o = 1'b0;
    if (f_req_i && d_req_i) begin
`ifdef ROM_ARB_RR_EN
      if (last_gnt_i == PORT_FETCH) d_gnt_o = 1'b1;
      else                          f_gnt_o = 1'b1;
`else
      if (consec_i == CW'(MAX_CONSEC)) f_gnt_o = 1'b1;
      else                             d_gnt_o = 1'b1;
`endif
    end else begin
      f_gnt_o = f_req_i;
      d_gnt_o = d_req_i;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - shares the single-port rom between fetch and data load; ROM_ARB_RR_EN selects round-robin
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ROM_BYTES  = 1024,
  parameter int MAX_CONSEC = 3
) (
  input  logic          clk,
  input  logic          reset,
  rom_arbiter_if.slave  bus
);

  localparam int CW = consec_w(MAX_CONSEC);

  port_e             last_gnt_q, last_gnt_d;
`ifndef ROM_ARB_RR_EN
  logic [CW-1:0]     consec_q, consec_d;
`endif
  logic              f_pick, d_pick;
  logic              f_gnt, d_gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic              addr_err;
  logic              f_rsp_valid_q, d_rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  rom_arb_pick #(
    .MAX_CONSEC (MAX_CONSEC),
    .CW         (CW)
  ) u_pick (
    .f_req_i    (bus.f_req),
    .d_req_i    (bus.d_req),
    .last_gnt_i (last_gnt_q),
`ifndef ROM_ARB_RR_EN
    .consec_i   (consec_q),
`endif
    .f_gnt_o    (f_pick),
    .d_gnt_o    (d_pick)
  );

  // Grant gating, address mux, range/alignment check and next arbitration state
  always_comb begin
    f_gnt      = f_pick & ~reset;
    d_gnt      = d_pick & ~reset;
    gnt_addr   = d_pick ? bus.d_addr : bus.f_addr;
    addr_err   = (gnt_addr >= ADDR_W'(ROM_BYTES)) || (gnt_addr[1:0] != 2'b00);
    last_gnt_d = last_gnt_q;
    if (d_gnt)      last_gnt_d = PORT_DATA;
    else if (f_gnt) last_gnt_d = PORT_FETCH;
`ifndef ROM_ARB_RR_EN
    consec_d = consec_q;
    if (!bus.f_req || f_gnt)                          consec_d = '0;
    else if (d_gnt && (consec_q != CW'(MAX_CONSEC)))  consec_d = consec_q + 1'b1;
`endif
  end

  // Arbitration history registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= PORT_FETCH;
`ifndef ROM_ARB_RR_EN
      consec_q   <= '0;
`endif
    end else begin
      last_gnt_q <= last_gnt_d;
`ifndef ROM_ARB_RR_EN
      consec_q   <= consec_d;
`endif
    end
  end

  // Response pipeline: capture rom word at end of the grant cycle, hold it otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      f_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      f_rsp_valid_q <= f_gnt;
      d_rsp_valid_q <= d_gnt;
      if (f_gnt || d_gnt) begin
        rsp_data_q <= addr_err ? DATA_W'(ERR_DATA) : bus.rom_data;
        rsp_err_q  <= addr_err;
      end
    end
  end

  // A response whose grant preceded reset is suppressed during the reset cycle too
  assign bus.f_gnt       = f_gnt;
  assign bus.d_gnt       = d_gnt;
  assign bus.rom_address = gnt_addr;
  assign bus.f_rsp_valid = f_rsp_valid_q & ~reset;
  assign bus.d_rsp_valid = d_rsp_valid_q & ~reset;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - scoreboard bench for rom_arbiter; ROM_ARB_RR_EN selects round-robin expectations
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int ROM_BYTES  = 1024;
  localparam int MAX_CONSEC = 3;

`ifdef ROM_ARB_RR_EN
  localparam logic [5:0] EXP_SEQ6 = 6'b101010;
  localparam logic [3:0] EXP_SEQ4 = 4'b1010;
`else
  localparam logic [5:0] EXP_SEQ6 = 6'b111011;
  localparam logic [3:0] EXP_SEQ4 = 4'b1110;
`endif

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_mem [0:255];
  rsp_t        sbq [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hold_data;
  logic        hold_err;
  logic        hold_known = 1'b0;
  int          m_last;
  int          m_consec;
  logic [5:0]  gseq;
  logic        r_fr, r_dr;
  logic [31:0] r_fa, r_da;

  always #5 clk = ~clk;

  rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .ROM_BYTES  (ROM_BYTES),
    .MAX_CONSEC (MAX_CONSEC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rom_data = rom_mem[bus.rom_address[9:2]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a >= 32'(ROM_BYTES)) || (a[1:0] != 2'b00);
  endfunction

  // One clock: drive, check grants and the response due now, push new expectation
  task automatic cycle(input logic rst, input logic fr, input logic [31:0] fa,
                       input logic dr, input logic [31:0] da);
    logic        ef, ed, ev_f, ev_d;
    logic [31:0] ea;
    rsp_t        r, n;
    reset      = rst;
    bus.f_req  = fr;
    bus.f_addr = fa;
    bus.d_req  = dr;
    bus.d_addr = da;
    #2;
    ef = 1'b0;
    ed = 1'b0;
    if (!rst) begin
      if (fr && dr) begin
`ifdef ROM_ARB_RR_EN
        ed = (m_last == 0);
`else
        ed = (m_consec != MAX_CONSEC);
`endif
        ef = !ed;
      end else begin
        ef = fr;
        ed = dr;
      end
    end
    chk("f_gnt", bus.f_gnt, ef);
    chk("d_gnt", bus.d_gnt, ed);
    ea = ed ? da : fa;
    if (!rst) chk("rom_address", bus.rom_address, ea);
    ev_f = 1'b0;
    ev_d = 1'b0;
    if (sbq.size() > 0) begin
      r = sbq.pop_front();
      if (!rst) begin
        ev_f       = (r.port == 1'b0);
        ev_d       = r.port;
        hold_data  = r.data;
        hold_err   = r.err;
        hold_known = 1'b1;
      end
    end
    chk("f_rsp_valid", bus.f_rsp_valid, ev_f);
    chk("d_rsp_valid", bus.d_rsp_valid, ev_d);
    if (hold_known && !rst) begin
      chk("rsp_data", bus.rsp_data, hold_data);
      chk("rsp_err", bus.rsp_err, hold_err);
    end
    if (ef || ed) begin
      n.port = ed;
      n.err  = bad_addr(ea);
      n.data = n.err ? 32'h0 : rom_mem[ea[9:2]];
      sbq.push_back(n);
      gseq = {gseq[4:0], ed};
    end
    if (rst) begin
      m_last     = 0;
      m_consec   = 0;
      sbq.delete();
      hold_data  = 32'h0;
      hold_err   = 1'b0;
      hold_known = 1'b1;
    end else begin
      if (ed)      m_last = 1;
      else if (ef) m_last = 0;
      if (!fr || ef)                        m_consec = 0;
      else if (ed && m_consec < MAX_CONSEC) m_consec = m_consec + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    reset      = 1'b1;
    bus.f_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.f_addr = '0;
    bus.d_addr = '0;
    m_last     = 0;
    m_consec   = 0;
    gseq       = '0;
    @(posedge clk);
    #1;

    cycle(1'b1, 1'b1, 32'h0, 1'b1, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    gseq = '0;
    repeat (6) cycle(1'b0, 1'b1, 32'h10, 1'b1, 32'h20);
    chk("contention_seq", gseq, EXP_SEQ6);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h400);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h6);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h3FC);
    cycle(1'b0, 1'b1, 32'h3FF, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    repeat (2) cycle(1'b0, 1'b1, 32'h30, 1'b1, 32'h40);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    gseq = '0;
    repeat (4) cycle(1'b0, 1'b1, 32'h50, 1'b1, 32'h60);
    chk("post_reset_seq", gseq[3:0], EXP_SEQ4);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 80; i++) begin
      r_fr = 1'($urandom_range(0, 3) != 0);
      r_dr = 1'($urandom_range(0, 2) != 0);
      r_fa = 32'($urandom_range(0, 1100)) & 32'hFFFF_FFFC;
      r_da = 32'($urandom_range(0, 1100)) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) r_da[1:0] = 2'($urandom_range(1, 3));
      cycle(1'b0, r_fr, r_fa, r_dr, r_da);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
